prog_clockdiv: RTL and testbench
================================

PROG_CLOCKDIV -- requirements
Module: prog_clockdiv

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of half-period value and counter.
REQ-003 SHALL have parameter DEFAULT_HALF, default 25000000, half-period loaded into every channel at reset.
REQ-004 SHALL have port iclk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port en  in  CHANNELS  per-channel run enable.
REQ-007 SHALL have port load  in  1  single-cycle strobe writing a new half-period.
REQ-008 SHALL have port load_ch  in  $clog2(CHANNELS) (min 1)  target channel of load; values >= CHANNELS ignored.
REQ-009 SHALL have port load_half  in  CNT_WIDTH  new half-period in iclk cycles.
REQ-010 SHALL have port oclk  out  CHANNELS  divided clock per channel, registered.
REQ-011 SHALL have port otick  out  CHANNELS  one-cycle pulse coincident with each oclk rising edge.
REQ-012 SHALL have port pending  out  CHANNELS  high while a loaded value awaits application.

Function
REQ-013 Each channel SHALL hold state STOP (en low or active half = 0) or RUN (en high and active half >= 1).
REQ-014 In RUN, count SHALL increment by 1 per cycle; at count == half-1 it SHALL wrap to 0 and toggle oclk, giving period 2*half cycles, 50% duty.
REQ-015 otick SHALL be 1 for exactly the cycle in which oclk transitions 0->1 is registered (same edge), else 0.
REQ-016 half = 1 SHALL yield oclk toggling every cycle (period 2); otick high every other cycle.
REQ-017 In STOP, count SHALL be 0, oclk 0, otick 0 from the first edge after en falls (immediate, may truncate a high phase).
REQ-018 STOP->RUN on en rising: first toggle (0->1, otick) SHALL occur half cycles after the enabling edge.
REQ-019 load with valid load_ch SHALL write pend_half and set pending[ch] on the next edge; a later load before application overwrites pend_half.
REQ-020 A pending value SHALL be applied glitch-free only at the wrap where oclk falls 1->0 (end of full period), clearing pending; count restarts at 0.
REQ-021 A pending value on a channel in STOP SHALL be applied on the edge after it is written.
REQ-022 load in the same cycle as an application edge SHALL not be lost: the old pend_half is applied, the new value becomes pending.
REQ-023 Applying half = 0 SHALL place the channel in STOP with oclk 0 until a nonzero value is applied.
REQ-024 Counter arithmetic SHALL be unsigned CNT_WIDTH; count never exceeds half-1, no overflow path.
REQ-025 Channels SHALL be fully independent; loads to one never perturb another's phase.

Reset
REQ-026 reset asserted SHALL asynchronously force, per channel: count 0, oclk 0, otick 0, pending 0, active half DEFAULT_HALF, pend_half 0.
REQ-027 Reset mid-period SHALL discard any pending load; first toggle after release follows REQ-018 timing from the first edge with reset low and en high.

Structure
REQ-028 A shared package clockdiv_pkg SHALL hold the channel state enum (STOP, RUN) and DEFAULT_HALF constant.
REQ-029 One sub-module clockdiv_chan SHALL implement a single channel (counter, toggle, pending register); top SHALL instantiate CHANNELS copies via generate and decode load_ch.

Verification
REQ-030 CHANNELS=2, CNT_WIDTH=8, DEFAULT_HALF=3, en=11 after reset -> oclk period 6, high 3 cycles, otick once per 6 cycles on both.
REQ-031 Mid-high-phase load ch0 half=5 -> pending[0]=1 until next 1->0 edge; thereafter period 10; ch1 unchanged period 6.
REQ-032 Two loads ch0 (half=2 then half=7) within one period -> only 7 applied; period 14.
REQ-033 en[0] dropped mid high phase -> oclk[0]=0 next edge; re-enable -> first rise 3 cycles later with otick.
REQ-034 load ch1 half=0 -> ch1 stops low at period end; load half=1 while stopped -> applied next edge, period 2.
REQ-035 reset pulsed with pending[0]=1 mid-count -> all outputs 0 immediately, pending cleared, period returns to 6.

Source files
------------

// File: rtl/clockdiv_pkg.sv
// Shared types and constants for the programmable multi-channel clock divider.
package clockdiv_pkg;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } chan_state_e;

  localparam int unsigned DEFAULT_HALF_RST = 32'd25000000;

endpackage

// File: rtl/clockdiv_chan.sv
// One divider channel: half-period counter, output toggle, and a pending
// half-period register that is only committed at the end of a full period.
module clockdiv_chan
  import clockdiv_pkg::*;
#(
  parameter int unsigned           CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0]  RST_HALF  = CNT_WIDTH'(DEFAULT_HALF_RST)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 load_i,
  input  logic [CNT_WIDTH-1:0] load_half_i,
  output logic                 oclk_o,
  output logic                 otick_o,
  output logic                 pending_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] half_q;
  logic [CNT_WIDTH-1:0] pend_half_q;
  logic                 oclk_q, tick_q, pend_q;
  logic                 wrapNow;
  chan_state_e          state_d;

  // A channel with a zero half-period can never run, regardless of enable.
  always_comb begin
    state_d = (en_i && (half_q != '0)) ? RUN : STOP;
    wrapNow = (cnt_q >= (half_q - CNT_WIDTH'(1)));
    cnt_d   = wrapNow ? '0 : (cnt_q + CNT_WIDTH'(1));
  end

  // New half-periods take effect only on the falling wrap (or at once when
  // stopped); a load on that same edge is kept as the next pending value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      half_q      <= RST_HALF;
      pend_half_q <= '0;
      oclk_q      <= 1'b0;
      tick_q      <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      case (state_d)
        STOP: begin
          cnt_q  <= '0;
          oclk_q <= 1'b0;
          tick_q <= 1'b0;
          if (pend_q) begin
            half_q <= pend_half_q;
            pend_q <= 1'b0;
          end
        end
        RUN: begin
          cnt_q  <= cnt_d;
          tick_q <= wrapNow && !oclk_q;
          if (wrapNow) begin
            oclk_q <= !oclk_q;
            if (oclk_q && pend_q) begin
              half_q <= pend_half_q;
              pend_q <= 1'b0;
            end
          end
        end
      endcase
      if (load_i) begin
        pend_half_q <= load_half_i;
        pend_q      <= 1'b1;
      end
    end
  end

  assign oclk_o    = oclk_q;
  assign otick_o   = tick_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/prog_clockdiv.sv
// Programmable clock divider: CHANNELS independent channels sharing one
// load port, with load_ch selecting which channel receives a new half-period.
module prog_clockdiv
  import clockdiv_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned CNT_WIDTH    = 32,
  parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_RST,
  localparam int unsigned SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 iclk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  en,
  input  logic                 load,
  input  logic [SEL_W-1:0]     load_ch,
  input  logic [CNT_WIDTH-1:0] load_half,
  output logic [CHANNELS-1:0]  oclk,
  output logic [CHANNELS-1:0]  otick,
  output logic [CHANNELS-1:0]  pending
);

  logic [31:0]         loadSel;
  logic [CHANNELS-1:0] chanLoad;

  // Out-of-range selects match no channel and are silently dropped.
  assign loadSel = {{(32-SEL_W){1'b0}}, load_ch};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign chanLoad[i] = load && (loadSel == i);

    clockdiv_chan #(
      .CNT_WIDTH (CNT_WIDTH),
      .RST_HALF  (CNT_WIDTH'(DEFAULT_HALF))
    ) u_chan (
      .clk_i       (iclk),
      .rst_i       (reset),
      .en_i        (en[i]),
      .load_i      (chanLoad[i]),
      .load_half_i (load_half),
      .oclk_o      (oclk[i]),
      .otick_o     (otick[i]),
      .pending_o   (pending[i])
    );
  end

endmodule

// File: tb/tb_prog_clockdiv.sv
// Self-checking bench for prog_clockdiv: directed scenarios plus random loads
// and enables, compared every cycle against a period-based reference model.
module tb_prog_clockdiv;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam int DH  = 3;

  logic          iclk;
  logic          reset;
  logic [NCH-1:0] en;
  logic          load;
  logic [0:0]    load_ch;
  logic [CW-1:0] load_half;
  logic [NCH-1:0] oclk, otick, pending;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: elapsed edges within the current full period.
  int mHalf[NCH], mPendHalf[NCH], mK[NCH];
  bit mPend[NCH], mOclk[NCH], mTick[NCH];

  prog_clockdiv #(
    .CHANNELS     (NCH),
    .CNT_WIDTH    (CW),
    .DEFAULT_HALF (DH)
  ) dut (
    .iclk      (iclk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_ch   (load_ch),
    .load_half (load_half),
    .oclk      (oclk),
    .otick     (otick),
    .pending   (pending)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NCH; c++) begin
      mHalf[c] = DH; mPendHalf[c] = 0; mK[c] = 0;
      mPend[c] = 0;  mOclk[c] = 0;     mTick[c] = 0;
    end
  endtask

  // High for elapsed edges h..2h-1 of a period; the period closes at 2h.
  task automatic modelStep();
    if (reset) begin
      modelReset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (en[c] && mHalf[c] != 0) begin
          mK[c]++;
          mTick[c] = (mK[c] == mHalf[c]);
          mOclk[c] = (mK[c] >= mHalf[c]) && (mK[c] < 2 * mHalf[c]);
          if (mK[c] == 2 * mHalf[c]) begin
            mK[c] = 0;
            if (mPend[c]) begin mHalf[c] = mPendHalf[c]; mPend[c] = 0; end
          end
        end else begin
          mK[c] = 0; mOclk[c] = 0; mTick[c] = 0;
          if (mPend[c]) begin mHalf[c] = mPendHalf[c]; mPend[c] = 0; end
        end
        if (load && int'(load_ch) == c) begin
          mPendHalf[c] = int'(load_half);
          mPend[c]     = 1;
        end
      end
    end
  endtask

  task automatic stepCycle();
    logic [NCH-1:0] eo, et, ep;
    @(posedge iclk);
    modelStep();
    #1;
    for (int c = 0; c < NCH; c++) begin
      eo[c] = mOclk[c]; et[c] = mTick[c]; ep[c] = mPend[c];
    end
    checkOutput("oclk", oclk, eo);
    checkOutput("otick", otick, et);
    checkOutput("pending", pending, ep);
  endtask

  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) stepCycle();
  endtask

  task automatic doLoad(input int ch, input int half);
    load = 1'b1; load_ch = 1'(ch); load_half = CW'(half);
    stepCycle();
    load = 1'b0;
  endtask

  task automatic waitHigh0();
    for (int n = 0; n < 30 && !oclk[0]; n++) stepCycle();
    checkOutput("waitHigh0", oclk[0], 1);
  endtask

  initial begin
    int ticks0, ticks1, n;
    reset = 1'b1; en = '0; load = 1'b0; load_ch = '0; load_half = '0;
    modelReset();
    #3;
    checkOutput("rstOclk", oclk, 0);
    checkOutput("rstOtick", otick, 0);
    checkOutput("rstPending", pending, 0);
    @(posedge iclk); #1;
    reset = 1'b0; en = 2'b11;

    // Default half 3: two ticks per channel in 12 cycles.
    ticks0 = 0; ticks1 = 0;
    for (int k = 0; k < 12; k++) begin
      stepCycle();
      ticks0 += int'(otick[0]); ticks1 += int'(otick[1]);
    end
    checkOutput("ticks0Def", ticks0, 2);
    checkOutput("ticks1Def", ticks1, 2);

    // Drop enable mid high phase, then re-enable.
    waitHigh0();
    en[0] = 1'b0;
    stepCycle();
    checkOutput("dropLow", oclk[0], 0);
    en[0] = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      stepCycle(); n++;
      if (otick[0]) break;
    end
    checkOutput("reenableRise", n, 3);

    // Mid-high load is held pending until the falling wrap.
    waitHigh0();
    doLoad(0, 5);
    checkOutput("pendHeld", pending[0], 1);
    applyStimulus(40);

    // Back-to-back loads: only the last is applied.
    doLoad(0, 2);
    applyStimulus(2);
    doLoad(0, 7);
    applyStimulus(50);

    // Zero half stops channel 1; half 1 while stopped applies next edge.
    doLoad(1, 0);
    applyStimulus(20);
    checkOutput("stopLow", oclk[1], 0);
    doLoad(1, 1);
    applyStimulus(10);

    // Async reset with a pending load mid-count.
    doLoad(0, 4);
    #2 reset = 1'b1;
    #1 modelReset();
    checkOutput("arstOclk", oclk, 0);
    checkOutput("arstPending", pending, 0);
    stepCycle();
    reset = 1'b0;
    ticks0 = 0;
    for (int k = 0; k < 12; k++) begin
      stepCycle();
      ticks0 += int'(otick[0]);
    end
    checkOutput("ticks0PostRst", ticks0, 2);

    // Random enables and loads.
    for (int k = 0; k < 2000; k++) begin
      en[0] = ($urandom_range(0, 7) != 0);
      en[1] = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 7) == 0);
      load_ch = 1'($urandom_range(0, 1));
      load_half = CW'($urandom_range(0, 6));
      stepCycle();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
